mips_control_fsm: RTL and testbench

Multicycle MIPS main control unit. Decodes the 6-bit opcode from the instruction register and steps through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath enables and multiplexer selects, plus the 2-bit ALUOp that feeds ALUControl. It sits directly upstream of ALUControl and stalls on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/control_out_decode.sv | 81 ++++++++
 rtl/mips_control_fsm.sv | 88 ++++++++
 tb/tb_mips_control_fsm.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// datapath select codes and the bundled control vector.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegalop;
        logic       retire;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/control_out_decode.sv
// Combinational decode of FSM state (plus memory-ready and opcode) into the
// datapath control vector; reset masks every enable while keeping FETCH selects.
module control_out_decode
    import mips_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_rdy,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_rdy;
                ctrl.pcwrite = mem_rdy;
            end
            S_DECODE: begin
                // Branch target is precomputed here whatever the opcode turns out to be
                ctrl.alusrcb   = SRCB_IMMSH;
                ctrl.illegalop = !is_legal_op(op);
                ctrl.retire    = !is_legal_op(op);
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.retire   = mem_rdy;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
                ctrl.retire  = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
                ctrl.retire  = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (reset) begin
            ctrl         = '0;
            ctrl.alusrcb = SRCB_FOUR;
        end
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: state register and next-state logic; the
// per-state control vector comes from control_out_decode.
module mips_control_fsm
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       IllegalOp,
    output logic       Retire
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   mem_rdy;

    assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Op is only consulted in DECODE and MEMADR; elsewhere it is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:    if (mem_rdy) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    control_out_decode u_decode (
        .reset   (reset),
        .state   (state_q),
        .op      (Op),
        .mem_rdy (mem_rdy),
        .ctrl    (ctrl)
    );

    assign ALUOp     = ctrl.aluop;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign PCSrc     = ctrl.pcsrc;
    assign IorD      = ctrl.iord;
    assign MemWrite  = ctrl.memwrite;
    assign IRWrite   = ctrl.irwrite;
    assign PCWrite   = ctrl.pcwrite;
    assign Branch    = ctrl.branch;
    assign RegWrite  = ctrl.regwrite;
    assign RegDst    = ctrl.regdst;
    assign MemtoReg  = ctrl.memtoreg;
    assign IllegalOp = ctrl.illegalop;
    assign Retire    = ctrl.retire;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class cycle by
// cycle and compares the full control vector against hand-built expectations.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch, RegWrite;
    logic       RegDst, MemtoReg, IllegalOp, Retire;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mips_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .IllegalOp(IllegalOp), .Retire(Retire)
    );

    // {ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite, PCWrite,
    //  Branch, RegWrite, RegDst, MemtoReg, IllegalOp, Retire}
    logic [16:0] obs;
    assign obs = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite, PCWrite,
                  Branch, RegWrite, RegDst, MemtoReg, IllegalOp, Retire};

    function automatic logic [16:0] mk(
        input logic [1:0] aluop, input logic srca, input logic [1:0] srcb,
        input logic [1:0] pcsrc, input logic iord, input logic mw, input logic irw,
        input logic pcw, input logic br, input logic rw, input logic rd,
        input logic m2r, input logic ill, input logic ret);
        return {aluop, srca, srcb, pcsrc, iord, mw, irw, pcw, br, rw, rd, m2r, ill, ret};
    endfunction

    localparam logic [16:0] V_RESET    = {2'b00,1'b0,2'b01,2'b00, 10'b0000000000};
    localparam logic [16:0] V_FETCH    = {2'b00,1'b0,2'b01,2'b00, 10'b0011000000};
    localparam logic [16:0] V_FETCH_W  = {2'b00,1'b0,2'b01,2'b00, 10'b0000000000};
    localparam logic [16:0] V_DECODE   = {2'b00,1'b0,2'b11,2'b00, 10'b0000000000};
    localparam logic [16:0] V_ILLEGAL  = {2'b00,1'b0,2'b11,2'b00, 10'b0000000011};

    logic [16:0] v_memadr, v_memrd, v_memwb, v_memwr_w, v_memwr, v_exec, v_aluwb;
    logic [16:0] v_branch, v_addiexec, v_addiwb, v_jump;

    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input logic [16:0] exp);
        Op = op;
        MemReady = mr;
        #1;
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        @(negedge clk);
    endtask

    initial begin
        v_memadr   = mk(2'b00,1,2'b10,2'b00, 0,0,0,0,0,0,0,0,0,0);
        v_memrd    = mk(2'b00,0,2'b00,2'b00, 1,0,0,0,0,0,0,0,0,0);
        v_memwb    = mk(2'b00,0,2'b00,2'b00, 0,0,0,0,0,1,0,1,0,1);
        v_memwr_w  = mk(2'b00,0,2'b00,2'b00, 1,1,0,0,0,0,0,0,0,0);
        v_memwr    = mk(2'b00,0,2'b00,2'b00, 1,1,0,0,0,0,0,0,0,1);
        v_exec     = mk(2'b10,1,2'b00,2'b00, 0,0,0,0,0,0,0,0,0,0);
        v_aluwb    = mk(2'b00,0,2'b00,2'b00, 0,0,0,0,0,1,1,0,0,1);
        v_branch   = mk(2'b01,1,2'b00,2'b01, 0,0,0,0,1,0,0,0,0,1);
        v_addiexec = mk(2'b00,1,2'b10,2'b00, 0,0,0,0,0,0,0,0,0,0);
        v_addiwb   = mk(2'b00,0,2'b00,2'b00, 0,0,0,0,0,1,0,0,0,1);
        v_jump     = mk(2'b00,0,2'b00,2'b10, 0,0,0,1,0,0,0,0,0,1);

        reset = 1'b1;
        Op = 6'b000000;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset", 6'b100011, 1'b1, V_RESET);
        reset = 1'b0;

        // lw, no stalls: 5 cycles
        step("lw_fetch",  6'b000000, 1'b1, V_FETCH);
        step("lw_decode", 6'b100011, 1'b1, V_DECODE);
        step("lw_memadr", 6'b100011, 1'b1, v_memadr);
        step("lw_memrd",  6'b100011, 1'b1, v_memrd);
        step("lw_memwb",  6'b100011, 1'b1, v_memwb);

        // R-type: 4 cycles
        step("r_fetch",  6'b000000, 1'b1, V_FETCH);
        step("r_decode", 6'b000000, 1'b1, V_DECODE);
        step("r_exec",   6'b000000, 1'b1, v_exec);
        step("r_aluwb",  6'b000000, 1'b1, v_aluwb);

        // sw with 3 stall cycles in MEMWR: 7 cycles
        step("sw_fetch",   6'b101011, 1'b1, V_FETCH);
        step("sw_decode",  6'b101011, 1'b1, V_DECODE);
        step("sw_memadr",  6'b101011, 1'b1, v_memadr);
        step("sw_memwr_0", 6'b101011, 1'b0, v_memwr_w);
        step("sw_memwr_1", 6'b101011, 1'b0, v_memwr_w);
        step("sw_memwr_2", 6'b101011, 1'b0, v_memwr_w);
        step("sw_memwr_3", 6'b101011, 1'b1, v_memwr);

        // beq with one FETCH stall
        step("beq_fetch_w", 6'b000100, 1'b0, V_FETCH_W);
        step("beq_fetch",   6'b000100, 1'b1, V_FETCH);
        step("beq_decode",  6'b000100, 1'b1, V_DECODE);
        step("beq_branch",  6'b000100, 1'b1, v_branch);

        // j
        step("j_fetch",  6'b000010, 1'b1, V_FETCH);
        step("j_decode", 6'b000010, 1'b1, V_DECODE);
        step("j_jump",   6'b000010, 1'b1, v_jump);

        // addi
        step("addi_fetch",  6'b001000, 1'b1, V_FETCH);
        step("addi_decode", 6'b001000, 1'b1, V_DECODE);
        step("addi_exec",   6'b001000, 1'b1, v_addiexec);
        step("addi_wb",     6'b001000, 1'b1, v_addiwb);

        // illegal opcode: 2 cycles, back to FETCH
        step("ill_fetch",  6'b111111, 1'b1, V_FETCH);
        step("ill_decode", 6'b111111, 1'b1, V_ILLEGAL);
        step("ill_next",   6'b111111, 1'b1, V_FETCH);

        // lw with MEMRD stall and Op changing after MEMADR
        step("lw2_decode", 6'b100011, 1'b1, V_DECODE);
        step("lw2_memadr", 6'b100011, 1'b1, v_memadr);
        step("lw2_memrd_w", 6'b101011, 1'b0, v_memrd);
        step("lw2_memrd",  6'b000100, 1'b1, v_memrd);
        step("lw2_memwb",  6'b000010, 1'b1, v_memwb);

        // reset during MEMRD aborts the lw
        step("rst_fetch",  6'b100011, 1'b1, V_FETCH);
        step("rst_decode", 6'b100011, 1'b1, V_DECODE);
        step("rst_memadr", 6'b100011, 1'b1, v_memadr);
        reset = 1'b1;
        step("rst_in_memrd", 6'b100011, 1'b1, V_RESET);
        reset = 1'b0;
        step("rst_after",  6'b100011, 1'b1, V_FETCH);
        step("rst_decode2", 6'b000000, 1'b1, V_DECODE);
        step("rst_exec",   6'b000000, 1'b1, v_exec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
